// File: rtl/fifo_sync_prog_pkg.sv
// Shared types and elaboration helpers for fifo_sync_prog.
// Optional feature macro: FIFO_SYNC_PROG_FWFT_EN (first-word-fall-through read port).
package fifo_sync_prog_pkg;

  // Snapshot of every flag the FIFO exports, kept together so the top
  // builds them in one place and fans them out to ports.
  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  // Pointer/count width: one extra bit over the storage address so that
  // full and empty are distinguishable when the low bits match.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit in_range(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/fifo_sync_ptr.sv
// Wrapping CNT_W-bit FIFO pointer with increment enable; MSB is the wrap bit.
module fifo_sync_ptr #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] ptr_o
);

  logic [CNT_W-1:0] ptr_q, ptr_d;

  // Advance by one when enabled; natural overflow gives modulo 2^CNT_W.
  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) ptr_d = ptr_q + CNT_W'(1);
  end

  // Pointer register, cleared by async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty flags
// and sticky overflow/underflow errors.
// Macro FIFO_SYNC_PROG_FWFT_EN selects first-word-fall-through reads;
// left undefined the read port is registered with one-cycle latency.
module fifo_sync_prog
  import fifo_sync_prog_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int FIFO_DEPTH = 8,
  parameter  int AE_LEVEL   = 2,
  parameter  int AF_LEVEL   = 6,
  localparam int ADDR_W     = $clog2(FIFO_DEPTH),
  localparam int CNT_W      = cnt_w(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [CNT_W-1:0]      count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam logic [CNT_W-1:0] AE_C = CNT_W'(AE_LEVEL);
  localparam logic [CNT_W-1:0] AF_C = CNT_W'(AF_LEVEL);

  // Reject illegal configurations at elaboration rather than mis-behave.
  if (!is_pow2(FIFO_DEPTH)) begin : g_bad_depth
    $error("fifo_sync_prog: FIFO_DEPTH must be a power of two >= 2");
  end
  if (!in_range(AE_LEVEL, 0, FIFO_DEPTH - 1)) begin : g_bad_ae
    $error("fifo_sync_prog: AE_LEVEL out of range 0..FIFO_DEPTH-1");
  end
  if (!in_range(AF_LEVEL, 1, FIFO_DEPTH)) begin : g_bad_af
    $error("fifo_sync_prog: AF_LEVEL out of range 1..FIFO_DEPTH");
  end
  if (DATA_WIDTH < 1) begin : g_bad_dw
    $error("fifo_sync_prog: DATA_WIDTH must be >= 1");
  end

  logic [CNT_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      cnt;
  logic                  wr_acc, rd_acc;
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  fifo_status_t          st;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  assign cnt = wr_ptr - rd_ptr;

  // Flags derive only from pointer and error registers, never from the
  // request inputs, so acceptance below sees last cycle's full/empty.
  always_comb begin
    st              = '0;
    st.empty        = (wr_ptr == rd_ptr);
    st.full         = (wr_ptr[CNT_W-1] != rd_ptr[CNT_W-1]) &&
                      (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    st.almost_empty = (cnt <= AE_C);
    st.almost_full  = (cnt >= AF_C);
    st.overflow     = ovf_q;
    st.underflow    = udf_q;
  end

  // A write into a full FIFO is dropped even if a read frees a slot in the
  // same cycle; likewise a read of an empty FIFO is not satisfied by a
  // simultaneous write.
  always_comb begin
    wr_acc = cs & wr_en & ~st.full;
    rd_acc = cs & rd_en & ~st.empty;
  end

  fifo_sync_ptr #(.CNT_W(CNT_W)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (wr_acc),
    .ptr_o (wr_ptr)
  );

  fifo_sync_ptr #(.CNT_W(CNT_W)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (rd_acc),
    .ptr_o (rd_ptr)
  );

  // Storage is not reset; only slots between rd_ptr and wr_ptr are meaningful.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr[ADDR_W-1:0]] <= data_in;
  end

  // Sticky errors: a fresh error in the clearing cycle keeps the flag set.
  always_comb begin
    ovf_d = (ovf_q & ~clr_err) | (cs & wr_en & st.full);
    udf_d = (udf_q & ~clr_err) | (cs & rd_en & st.empty);
  end

  // Error flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

`ifdef FIFO_SYNC_PROG_FWFT_EN
  // Head word is always on the output; a pop exposes the next one.
  assign data_out  = mem_q[rd_ptr[ADDR_W-1:0]];
  assign valid_out = ~st.empty;
`else
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  vld_q,  vld_d;

  // Capture the head word on an accepted read; valid is a one-cycle pulse.
  always_comb begin
    dout_d = dout_q;
    vld_d  = rd_acc;
    if (rd_acc) dout_d = mem_q[rd_ptr[ADDR_W-1:0]];
  end

  // Registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      vld_q  <= vld_d;
    end
  end

  assign data_out  = dout_q;
  assign valid_out = vld_q;
`endif

  assign count        = cnt;
  assign empty        = st.empty;
  assign full         = st.full;
  assign almost_empty = st.almost_empty;
  assign almost_full  = st.almost_full;
  assign overflow     = st.overflow;
  assign underflow    = st.underflow;

endmodule

// File: tb/tb_fifo_sync_prog.sv
// Self-checking bench for fifo_sync_prog (DEPTH=8, AE=2, AF=6): directed
// scenarios followed by random traffic, all against a queue-based model.
module tb_fifo_sync_prog;

  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int AE = 2;
  localparam int AF = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cs, wr_en, rd_en, clr_err;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          valid_out, empty, full, almost_empty, almost_full;
  logic          overflow, underflow;
  logic [3:0]    count;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  bit            m_ovf, m_udf, m_vld;
  logic [DW-1:0] m_dout;

  fifo_sync_prog #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .AE_LEVEL(AE), .AF_LEVEL(AF)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(data_out), .valid_out(valid_out), .empty(empty),
    .full(full), .almost_empty(almost_empty), .almost_full(almost_full),
    .count(count), .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_udf = 0; m_vld = 0; m_dout = '0;
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ".count"}, 64'(count), 64'(n));
    chk({tag, ".empty"}, 64'(empty), 64'(n == 0));
    chk({tag, ".full"}, 64'(full), 64'(n == DEPTH));
    chk({tag, ".aempty"}, 64'(almost_empty), 64'(n <= AE));
    chk({tag, ".afull"}, 64'(almost_full), 64'(n >= AF));
    chk({tag, ".ovf"}, 64'(overflow), 64'(m_ovf));
    chk({tag, ".udf"}, 64'(underflow), 64'(m_udf));
`ifdef FIFO_SYNC_PROG_FWFT_EN
    chk({tag, ".valid"}, 64'(valid_out), 64'(n != 0));
    if (n != 0) chk({tag, ".dout"}, 64'(data_out), 64'(q[0]));
`else
    chk({tag, ".valid"}, 64'(valid_out), 64'(m_vld));
    chk({tag, ".dout"}, 64'(data_out), 64'(m_dout));
`endif
  endtask

  // One clock of stimulus: drive, advance the model across the edge, check.
  task automatic step(input string tag, input bit c, input bit w, input logic [DW-1:0] d,
                      input bit r, input bit cl);
    bit wacc, racc;
    int n;
    cs = c; wr_en = w; data_in = d; rd_en = r; clr_err = cl;
    @(posedge clk);
    n    = q.size();
    wacc = c && w && (n < DEPTH);
    racc = c && r && (n > 0);
    m_ovf = (m_ovf && !cl) || (c && w && n == DEPTH);
    m_udf = (m_udf && !cl) || (c && r && n == 0);
    m_vld = racc;
    if (racc) begin
      m_dout = q[0];
      void'(q.pop_front());
    end
    if (wacc) q.push_back(d);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst_n = 1'b0; cs = 0; wr_en = 0; rd_en = 0; clr_err = 0; data_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;
    step("idle", 1, 0, 0, 0, 0);

    // Fill with 0x11..0x88, then one overflowing write of 0x99
    for (int i = 1; i <= 8; i++) step("fill", 1, 1, DW'(i * 32'h11), 0, 0);
    step("ovf_write", 1, 1, 32'h99, 0, 0);

    // Drain, then read on empty
    for (int i = 0; i < 8; i++) step("drain", 1, 0, 0, 1, 0);
    step("drain_tail", 1, 0, 0, 0, 0);
    step("udf_read", 1, 0, 0, 1, 0);

    // Clear errors, fill to 4, stream for 20 cycles (pointers wrap)
    step("clr0", 1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step("pre4", 1, 1, DW'(32'h100 + i), 0, 0);
    for (int i = 0; i < 20; i++) step("stream", 1, 1, DW'(32'h200 + i), 1, 0);

    // Top up to full and exercise the clear-vs-new-error priority
    for (int i = 0; i < 4; i++) step("top", 1, 1, DW'(32'h300 + i), 0, 0);
    step("ovf2", 1, 1, 32'hdead, 0, 0);
    step("clr_alone", 1, 0, 0, 0, 1);
    step("ovf3", 1, 1, 32'hbeef, 0, 0);
    step("clr_vs_err", 1, 1, 32'hcafe, 0, 1);
    step("clr1", 1, 0, 0, 0, 1);

    // Deselected at full: nothing moves, no errors
    for (int i = 0; i < 4; i++) step("cs0_full", 0, 1, DW'(i), i[0], 0);
    for (int i = 0; i < 8; i++) step("drain2", 1, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step("cs0_empty", 0, i[0], DW'(i), 1, 0);

    // Reach count 5 then reset asynchronously mid-cycle
    for (int i = 0; i < 5; i++) step("pre_rst", 1, 1, DW'(32'h400 + i), 0, 0);
    step("pre_rst_rd", 1, 0, 0, 1, 0);
    step("pre_rst_wr", 1, 1, 32'h405, 0, 0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(posedge clk);
    #1;
    check_all("rst_held");
    rst_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(0, 7) != 0), ($urandom_range(0, 1) == 1), DW'($urandom),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_sync_prog.md
# fifo_sync_prog

Parametrised single-clock FIFO: the next-generation synchronous buffer for datapath decoupling between blocks in one clock domain. Adds to the basic full/empty FIFO an occupancy count, almost-full/almost-empty flags at parameter thresholds, and sticky overflow/underflow error flags with synchronous clear. Read output mode is either registered (one-cycle read latency) or first-word-fall-through, selected at compile time.

## Interface
- DATA_WIDTH, 32, word width in bits (≥1)
- FIFO_DEPTH, 8, number of entries; power of two, ≥2
- AE_LEVEL, 2, almost_empty asserted when count ≤ AE_LEVEL; range 0..FIFO_DEPTH-1
- AF_LEVEL, 6, almost_full asserted when count ≥ AF_LEVEL; range 1..FIFO_DEPTH
- Derived: ADDR_W = $clog2(FIFO_DEPTH), CNT_W = ADDR_W+1
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cs  in  1  chip select; when low, wr_en/rd_en are ignored and no error flag sets
- wr_en  in  1  write request
- data_in  in  DATA_WIDTH  write data
- rd_en  in  1  read request
- data_out  out  DATA_WIDTH  read data
- valid_out  out  1  data_out holds a valid read word
- empty  out  1  count == 0
- full  out  1  count == FIFO_DEPTH
- almost_empty  out  1  count ≤ AE_LEVEL
- almost_full  out  1  count ≥ AF_LEVEL
- count  out  CNT_W  current occupancy, 0..FIFO_DEPTH
- overflow  out  1  sticky: write request seen while full
- underflow  out  1  sticky: read request seen while empty
- clr_err  in  1  synchronous clear of overflow/underflow

## Operation
- Pointers wr_ptr/rd_ptr are CNT_W bits: low ADDR_W bits index storage, MSB is wrap bit. Increment modulo 2^CNT_W.
- count = wr_ptr − rd_ptr (modulo 2^CNT_W). full = MSBs differ and low bits equal; empty = pointers equal.
- Write accepted: cs & wr_en & !full → mem[wr_ptr] ← data_in, wr_ptr+1.
- Read accepted: cs & rd_en & !empty → rd_ptr+1.
- Acceptance uses registered flags only: write when full is rejected even if a read is accepted that cycle; read when empty is rejected even if a write is accepted that cycle.
- Simultaneous accepted read and write: count unchanged, both pointers advance.
- overflow sets on cs & wr_en & full; underflow on cs & rd_en & empty. clr_err clears both; a new error in the same cycle as clr_err wins (flag stays 1).
- All flags and count are registered-state functions; none depend combinationally on wr_en/rd_en.

## Timing
- Reset (async assert): pointers 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0 (unless AF_LEVEL=0 impossible by range), overflow 0, underflow 0, valid_out 0, data_out 0. Storage not reset. Reset mid-operation discards all contents.
- Write at edge N: count/empty/full/almost flags reflect it after edge N.
- Registered mode: accepted read at edge N → data_out and valid_out=1 valid after edge N; valid_out is 0 the cycle after a non-accepted read; data_out holds last value otherwise.
- Empty → write at edge N → read may be accepted at edge N+1 earliest.

## Configuration
- Macro FIFO_SYNC_PROG_FWFT_EN.
- Defined: first-word-fall-through. data_out = mem[rd_ptr] continuously, valid_out = !empty; word written at edge N is visible after edge N; accepted read pops the shown word and presents the next one after the edge. data_out undefined-but-stable when empty.
- Undefined: registered read mode as in Timing.

## Structure
- Package fifo_sync_prog_pkg: function for CNT_W derivation and localparam checks helper; typedef fifo_status_t packed struct {empty, full, almost_empty, almost_full, overflow, underflow}.
- Sub-module fifo_sync_ptr: CNT_W-bit pointer with increment enable and async reset, instanced twice (write, read).
- Elaboration-time checks: FIFO_DEPTH power of two, threshold ranges.

## Test plan
- Reset then idle → empty=1, almost_empty=1, full=0, count=0, overflow=underflow=0, valid_out=0.
- DEPTH=8: write 0x11..0x88 (8 words) → count=8, full=1, almost_full from count 6; ninth write → overflow=1, count stays 8, word 0x99 never read.
- Read all 8 → data order 0x11..0x88 (registered: each one cycle after rd_en; FWFT: 0x11 present before first rd_en); then rd_en on empty → underflow=1.
- Fill to 4, hold wr_en=rd_en=1 for 20 cycles with incrementing data → count stays 4, pointers wrap twice, output order preserved.
- overflow=1, assert clr_err alone → 0 next cycle; clr_err with simultaneous write-while-full → overflow stays 1.
- cs=0 with wr_en/rd_en toggling at full and empty → no pointer change, no error flags; assert rst_n=0 mid-stream at count 5 → all outputs return to reset values immediately.
